// File: rtl/rf_arb_pkg.sv
// Shared widths, requester indices and the buffered-write entry type for the
// register-file write arbiter.
package rf_arb_pkg;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  localparam int REQ_WB = 0;
  localparam int REQ_MC = 1;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Per-requester write FIFO; exposes every slot's valid/sel so the arbiter can
// answer "is a write to this register still in flight".
module rf_wr_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [SEL_W-1:0]              push_sel_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [SEL_W-1:0]              head_sel_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic                          head_valid_o,
  output logic                          full_o,
  output logic [DEPTH-1:0]              ent_valid_o,
  output logic [DEPTH-1:0][SEL_W-1:0]   ent_sel_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SEL_W-1:0]  sel_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o       = (cnt_q == CNT_W'(DEPTH));
  assign head_valid_o = (cnt_q != '0);
  assign do_push      = push_i & ~full_o;
  assign do_pop       = pop_i & head_valid_o;
  assign head_sel_o   = sel_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) begin
        sel_q[wr_ptr_q]  <= push_sel_i;
        data_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off            = PTR_W'(i) - rd_ptr_q;
    assign ent_valid_o[i] = ({1'b0, off} < cnt_q);
    assign ent_sel_o[i]   = sel_q[i];
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between pipeline writeback and
// the multicycle unit, with in-flight query and forwarding for decode.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W     = rf_arb_pkg::DATA_W,
  parameter int SEL_W      = rf_arb_pkg::SEL_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              write,
  output logic [SEL_W-1:0]  writeregsel,
  output logic [DATA_W-1:0] writedata,
  input  logic [SEL_W-1:0]  q1_sel,
  input  logic [SEL_W-1:0]  q2_sel,
  output logic              q1_pending,
  output logic              q2_pending,
  output logic              q1_fwd_valid,
  output logic              q2_fwd_valid,
  output logic [DATA_W-1:0] q1_fwd_data,
  output logic [DATA_W-1:0] q2_fwd_data,
  output logic              err
);
  logic                              req_valid [2];
  logic [SEL_W-1:0]                  req_sel   [2];
  logic [DATA_W-1:0]                 req_data  [2];
  logic                              push      [2];
  logic                              pop       [2];
  logic                              full      [2];
  logic                              hvalid    [2];
  logic [SEL_W-1:0]                  hsel      [2];
  logic [DATA_W-1:0]                 hdata     [2];
  logic [FIFO_DEPTH-1:0]             ent_vld   [2];
  logic [FIFO_DEPTH-1:0][SEL_W-1:0]  ent_sel   [2];

  logic              gnt_vld, gnt_idx;
  logic              rr_q, rr_d;
  logic              write_q;
  logic [SEL_W-1:0]  writeregsel_q;
  logic [DATA_W-1:0] writedata_q;
  logic              err_q, err_d;
  logic              stall_q [2];
  logic              stall_d [2];
  logic [SEL_W-1:0]  stall_sel_q  [2];
  logic [DATA_W-1:0] stall_data_q [2];
  logic [SEL_W-1:0]  qsel    [2];
  logic [1:0]        buf_hit;
  logic [1:0]        fwd;

  assign req_valid[0] = req0_valid;
  assign req_valid[1] = req1_valid;
  assign req_sel[0]   = req0_sel;
  assign req_sel[1]   = req1_sel;
  assign req_data[0]  = req0_data;
  assign req_data[1]  = req1_data;

  for (genvar r = 0; r < 2; r++) begin : g_fifo
    assign push[r] = req_valid[r] & ~full[r];
    assign pop[r]  = gnt_vld & (gnt_idx == 1'(r));

    rf_wr_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
    ) u_fifo (
      .clk_i        (clk),
      .rst_ni       (rst),
      .push_i       (push[r]),
      .push_sel_i   (req_sel[r]),
      .push_data_i  (req_data[r]),
      .pop_i        (pop[r]),
      .head_sel_o   (hsel[r]),
      .head_data_o  (hdata[r]),
      .head_valid_o (hvalid[r]),
      .full_o       (full[r]),
      .ent_valid_o  (ent_vld[r]),
      .ent_sel_o    (ent_sel[r])
    );
  end

  assign req0_ready = ~full[REQ_WB];
  assign req1_ready = ~full[REQ_MC];

  // Same destination on both heads: the multicycle op is older, so it goes first.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'(REQ_WB);
    rr_d    = rr_q;
    if (hvalid[REQ_WB] && hvalid[REQ_MC]) begin
      gnt_vld = 1'b1;
      if (hsel[REQ_WB] == hsel[REQ_MC]) begin
        gnt_idx = 1'(REQ_MC);
      end else begin
        gnt_idx = rr_q;
        rr_d    = ~rr_q;
      end
    end else if (hvalid[REQ_WB]) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'(REQ_WB);
    end else if (hvalid[REQ_MC]) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'(REQ_MC);
    end
  end

  always_comb begin
    err_d = err_q;
    for (int r = 0; r < 2; r++) begin
      stall_d[r] = req_valid[r] & full[r];
      if (stall_q[r] && (!req_valid[r] || req_sel[r] != stall_sel_q[r] ||
                         req_data[r] != stall_data_q[r]))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q          <= 1'b0;
      write_q       <= 1'b0;
      writeregsel_q <= '0;
      writedata_q   <= '0;
      err_q         <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        stall_q[r]      <= 1'b0;
        stall_sel_q[r]  <= '0;
        stall_data_q[r] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      write_q <= gnt_vld;
      if (gnt_vld) begin
        writeregsel_q <= hsel[gnt_idx];
        writedata_q   <= hdata[gnt_idx];
      end
      err_q <= err_d;
      for (int r = 0; r < 2; r++) begin
        stall_q[r]      <= stall_d[r];
        stall_sel_q[r]  <= req_sel[r];
        stall_data_q[r] <= req_data[r];
      end
    end
  end

  assign qsel[0] = q1_sel;
  assign qsel[1] = q2_sel;

  always_comb begin
    buf_hit = '0;
    for (int q = 0; q < 2; q++)
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < FIFO_DEPTH; i++)
          if (ent_vld[r][i] && ent_sel[r][i] == qsel[q]) buf_hit[q] = 1'b1;
  end

  assign fwd[0] = write_q & (writeregsel_q == q1_sel);
  assign fwd[1] = write_q & (writeregsel_q == q2_sel);

  assign write        = write_q;
  assign writeregsel  = writeregsel_q;
  assign writedata    = writedata_q;
  assign err          = err_q;
  assign q1_pending   = buf_hit[0] | fwd[0];
  assign q2_pending   = buf_hit[1] | fwd[1];
  assign q1_fwd_valid = fwd[0];
  assign q2_fwd_valid = fwd[1];
  assign q1_fwd_data  = fwd[0] ? writedata_q : '0;
  assign q2_fwd_data  = fwd[1] ? writedata_q : '0;
endmodule
